// File: rtl/fp_addsub_multichannel_ctrl.sv
// Multichannel FP add/sub controller: IEEE<->FloPoCo conversion around an external
// FPAddSub core, tag pipeline for in-order retire, and per-channel held results.
module fp_addsub_multichannel_ctrl #(
  parameter  int WE       = 8,
  parameter  int WF       = 23,
  parameter  int CORE_LAT = 2,
  parameter  int NCH      = 4,
  localparam int N        = WE + WF + 1,
  localparam int FW       = N + 2,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CNT_W    = $clog2(CORE_LAT + 3)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [CH_W-1:0]  ch,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             iter_reinit,
  output logic [FW-1:0]    core_x,
  output logic [FW-1:0]    core_y,
  input  logic [FW-1:0]    core_radd,
  input  logic [FW-1:0]    core_rsub,
  output logic [N-1:0]     result,
  output logic             finish,
  output logic [CH_W-1:0]  res_ch,
  output logic             finish_dash,
  output logic [N-1:0]     result_d,
  output logic [CH_W-1:0]  res_ch_d,
  output logic [NCH*N-1:0] held_out,
  output logic             busy,
  output logic [CNT_W-1:0] inflight
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Subnormals flush to +0; inf/NaN are moved into the exception field.
  function automatic logic [FW-1:0] ieee_to_fpc(input logic [N-1:0] v);
    logic [WE-1:0] e;
    logic [WF-1:0] f;
    logic [FW-1:0] r;
    e = v[N-2:WF];
    f = v[WF-1:0];
    if (e == {WE{1'b0}}) begin
      r = {FW{1'b0}};
    end else if (e == {WE{1'b1}}) begin
      if (f == {WF{1'b0}}) begin
        r = {2'b10, v};
      end else begin
        r = {2'b11, v};
      end
    end else begin
      r = {2'b01, v};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] fpc_to_ieee(input logic [FW-1:0] x);
    logic [N-1:0] r;
    case (x[FW-1:FW-2])
      2'b00:   r = {N{1'b0}};
      2'b01:   r = x[N-1:0];
      2'b10:   r = {x[N-1], {WE{1'b1}}, {WF{1'b0}}};
      2'b11:   r = {1'b0, {WE{1'b1}}, 1'b1, {(WF-1){1'b0}}};
      default: r = {N{1'b0}};
    endcase
    return r;
  endfunction

  logic [FW-1:0]                core_x_q, core_x_d, core_y_q, core_y_d;
  logic [CORE_LAT:0]            tag_vld_q, tag_vld_d, tag_op_q, tag_op_d;
  logic [CORE_LAT:0][CH_W-1:0]  tag_ch_q, tag_ch_d;
  logic [N-1:0]                 rslt_q, rslt_d, dash_rslt_q, dash_rslt_d;
  logic                         fin_q, fin_d, dash_q, dash_d;
  logic [CH_W-1:0]              rch_q, rch_d, dash_ch_q, dash_ch_d;
  logic [N-1:0]                 held_q [NCH];
  logic [N-1:0]                 held_d [NCH];
  logic [CNT_W-1:0]             inflight_q, inflight_d;
  logic                         busy_q, busy_d;
  logic [FW-1:0]                retire_s;

  // Issue stage and tag pipeline; op and ch travel with each tag.
  always_comb begin
    core_x_d  = core_x_q;
    core_y_d  = core_y_q;
    if (start) begin
      core_x_d = ieee_to_fpc(a);
      core_y_d = ieee_to_fpc(b);
    end else begin
      core_x_d = core_x_q;
      core_y_d = core_y_q;
    end
    tag_vld_d = {tag_vld_q[CORE_LAT-1:0], start};
    tag_op_d  = {tag_op_q[CORE_LAT-1:0], op & start};
    tag_ch_d  = {tag_ch_q[CORE_LAT-1:0], (start ? ch : {CH_W{1'b0}})};
  end

  // Retire stage picks the core output named by the tag, then the delayed copy.
  always_comb begin
    retire_s = tag_op_q[CORE_LAT] ? core_rsub : core_radd;
    fin_d    = tag_vld_q[CORE_LAT];
    rslt_d   = rslt_q;
    rch_d    = rch_q;
    if (tag_vld_q[CORE_LAT]) begin
      rslt_d = fpc_to_ieee(retire_s);
      rch_d  = tag_ch_q[CORE_LAT];
    end else begin
      rslt_d = rslt_q;
      rch_d  = rch_q;
    end
    dash_d      = fin_q;
    dash_rslt_d = rslt_q;
    dash_ch_d   = rch_q;
  end

  // In-flight counter: a start and a finish in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (start && !fin_q) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!start && fin_q) begin
      inflight_d = inflight_q - CNT_ONE;
    end else begin
      inflight_d = inflight_q;
    end
    busy_d = (inflight_d != {CNT_W{1'b0}});
  end

  // Held results: the delayed write wins on its channel, reinit clears the rest.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      held_d[c] = held_q[c];
      if (dash_q && (dash_ch_q == CH_W'(c))) begin
        held_d[c] = dash_rslt_q;
      end else if (!iter_reinit) begin
        held_d[c] = {N{1'b0}};
      end else begin
        held_d[c] = held_q[c];
      end
    end
  end

  // Bypass lets a consumer see the delayed result in the cycle it is written.
  always_comb begin
    held_out = {(NCH*N){1'b0}};
    for (int c = 0; c < NCH; c++) begin
      if (dash_q && (dash_ch_q == CH_W'(c))) begin
        held_out[c*N +: N] = dash_rslt_q;
      end else begin
        held_out[c*N +: N] = held_q[c];
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_x_q    <= {FW{1'b0}};
      core_y_q    <= {FW{1'b0}};
      tag_vld_q   <= {(CORE_LAT+1){1'b0}};
      tag_op_q    <= {(CORE_LAT+1){1'b0}};
      tag_ch_q    <= {((CORE_LAT+1)*CH_W){1'b0}};
      rslt_q      <= {N{1'b0}};
      fin_q       <= 1'b0;
      rch_q       <= {CH_W{1'b0}};
      dash_q      <= 1'b0;
      dash_rslt_q <= {N{1'b0}};
      dash_ch_q   <= {CH_W{1'b0}};
      inflight_q  <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        held_q[c] <= {N{1'b0}};
      end
    end else begin
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      tag_vld_q   <= tag_vld_d;
      tag_op_q    <= tag_op_d;
      tag_ch_q    <= tag_ch_d;
      rslt_q      <= rslt_d;
      fin_q       <= fin_d;
      rch_q       <= rch_d;
      dash_q      <= dash_d;
      dash_rslt_q <= dash_rslt_d;
      dash_ch_q   <= dash_ch_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      for (int c = 0; c < NCH; c++) begin
        held_q[c] <= held_d[c];
      end
    end
  end

  assign core_x      = core_x_q;
  assign core_y      = core_y_q;
  assign result      = rslt_q;
  assign finish      = fin_q;
  assign res_ch      = rch_q;
  assign finish_dash = dash_q;
  assign result_d    = dash_rslt_q;
  assign res_ch_d    = dash_ch_q;
  assign busy        = busy_q;
  assign inflight    = inflight_q;

endmodule

// File: tb/tb_fp_addsub_multichannel_ctrl.sv
// Bench for fp_addsub_multichannel_ctrl: behavioural FP core with 2-cycle latency,
// directed scenarios plus randomized traffic scored against a real-arithmetic model.
module tb_fp_addsub_multichannel_ctrl;
  localparam int CORE_LAT = 2;
  localparam int NCH      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, op = 1'b0, iter_reinit = 1'b1;
  logic [1:0]  ch = 2'd0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [33:0] core_x, core_y, core_radd, core_rsub;
  logic [31:0] result, result_d;
  logic        finish, finish_dash, busy;
  logic [1:0]  res_ch, res_ch_d;
  logic [127:0] held_out;
  logic [2:0]  inflight;

  always #5 clk = ~clk;

  fp_addsub_multichannel_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ch(ch), .a(a), .b(b),
    .iter_reinit(iter_reinit), .core_x(core_x), .core_y(core_y),
    .core_radd(core_radd), .core_rsub(core_rsub), .result(result), .finish(finish),
    .res_ch(res_ch), .finish_dash(finish_dash), .result_d(result_d), .res_ch_d(res_ch_d),
    .held_out(held_out), .busy(busy), .inflight(inflight)
  );

  // ---------------- arithmetic reference (exact for the operands used) -------------
  function automatic real ieee_val(input logic [31:0] v);
    logic [10:0] e;
    e = {3'b000, v[30:23]} + 11'd896;
    return $bitstoreal({v[31], e, v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_ieee(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // kinds: 0 zero, 1 number, 2 infinity, 3 NaN; b side already negated for subtraction
  function automatic logic [31:0] arith(input int ka, input logic sa, input real va,
                                        input int kb, input logic sb, input real vb);
    if (ka == 3 || kb == 3) return 32'h7FC00000;
    if (ka == 2 && kb == 2) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
    if (ka == 2) return {sa, 8'hFF, 23'h0};
    if (kb == 2) return {sb, 8'hFF, 23'h0};
    return real_to_ieee(va + vb);
  endfunction

  function automatic int ieee_kind(input logic [31:0] v);
    if (v[30:23] == 8'h00) return 0;
    if (v[30:23] == 8'hFF) return (v[22:0] == 23'h0) ? 2 : 3;
    return 1;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic o);
    int  kx, ky;
    real vx, vy;
    kx = ieee_kind(x);
    ky = ieee_kind(y);
    vx = (kx == 1) ? ieee_val(x) : 0.0;
    vy = (ky == 1) ? ieee_val(y) : 0.0;
    if (o) vy = -vy;
    return arith(kx, x[31], vx, ky, y[31] ^ o, vy);
  endfunction

  // external core stand-in: works purely from the FloPoCo exception field
  function automatic logic [33:0] core_fn(input logic [33:0] x, input logic [33:0] y, input logic o);
    int  kx, ky;
    real vx, vy;
    logic [31:0] r;
    logic [1:0]  ex;
    kx = int'(x[33:32]);
    ky = int'(y[33:32]);
    vx = (kx == 1) ? ieee_val(x[31:0]) : 0.0;
    vy = (ky == 1) ? ieee_val(y[31:0]) : 0.0;
    if (o) vy = -vy;
    r = arith(kx, x[31], vx, ky, y[31] ^ o, vy);
    if (r == 32'h0) ex = 2'b00;
    else if (r[30:23] == 8'hFF) ex = (r[22:0] == 23'h0) ? 2'b10 : 2'b11;
    else ex = 2'b01;
    return {ex, r};
  endfunction

  logic [33:0] c1_add = 34'h0, c1_sub = 34'h0, c2_add = 34'h0, c2_sub = 34'h0;
  always @(posedge clk) begin
    c1_add <= core_fn(core_x, core_y, 1'b0);
    c1_sub <= core_fn(core_x, core_y, 1'b1);
    c2_add <= c1_add;
    c2_sub <= c1_sub;
  end
  assign core_radd = c2_add;
  assign core_rsub = c2_sub;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          issue;
    int          due;
    logic [31:0] res;
    logic [1:0]  ch;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mheld [NCH];
  logic        dash_v = 1'b0;
  logic [31:0] dash_res = 32'h0;
  logic [1:0]  dash_ch = 2'd0;
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic mon_check();
    int          n_in;
    logic        ef;
    exp_t        e;
    logic [31:0] exp_h;
    n_in = 0;
    foreach (q[i]) if (q[i].issue < cyc) n_in++;
    n_chk++;
    if (inflight !== 3'(n_in)) $display("FAIL inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, n_in);
    else n_pass++;
    n_chk++;
    if (busy !== (n_in != 0)) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (n_in != 0));
    else n_pass++;
    ef = 1'b0;
    if (q.size() > 0) ef = (q[0].due == cyc);
    n_chk++;
    if (finish !== ef) $display("FAIL finish cyc=%0d got=%b exp=%b", cyc, finish, ef);
    else n_pass++;
    if (ef) begin
      e = q.pop_front();
      n_chk++;
      if (result !== e.res) $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, e.res);
      else n_pass++;
      n_chk++;
      if (res_ch !== e.ch) $display("FAIL res_ch cyc=%0d got=%0d exp=%0d", cyc, res_ch, e.ch);
      else n_pass++;
    end
    n_chk++;
    if (finish_dash !== dash_v) $display("FAIL finish_dash cyc=%0d got=%b exp=%b", cyc, finish_dash, dash_v);
    else n_pass++;
    if (dash_v) begin
      n_chk++;
      if (result_d !== dash_res || res_ch_d !== dash_ch)
        $display("FAIL result_d cyc=%0d got=%h/%0d exp=%h/%0d", cyc, result_d, res_ch_d, dash_res, dash_ch);
      else n_pass++;
    end
    for (int c = 0; c < NCH; c++) begin
      exp_h = (dash_v && dash_ch == 2'(c)) ? dash_res : mheld[c];
      n_chk++;
      if (held_out[c*32 +: 32] !== exp_h)
        $display("FAIL held_out[%0d] cyc=%0d got=%h exp=%h", c, cyc, held_out[c*32 +: 32], exp_h);
      else n_pass++;
    end
    for (int c = 0; c < NCH; c++) begin
      if (dash_v && dash_ch == 2'(c)) mheld[c] = dash_res;
      else if (!iter_reinit) mheld[c] = 32'h0;
    end
    dash_v = ef;
    if (ef) begin
      dash_res = e.res;
      dash_ch  = e.ch;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_en) mon_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic o, input logic [1:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1; op = o; ch = c; a = x; b = y;
    e.issue = cyc; e.due = cyc + CORE_LAT + 2; e.res = ref_add(x, y, o); e.ch = c;
    q.push_back(e);
    step();
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; start = 1'b0; mon_en = 1'b0;
    q.delete();
    for (int c = 0; c < NCH; c++) mheld[c] = 32'h0;
    dash_v = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] sp [8];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h80400000};
    if ($urandom_range(0, 4) == 0) return sp[$urandom_range(0, 7)];
    return real_to_ieee(real'(int'($urandom_range(0, 2000)) - 1000));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset(2);
    n_chk++;
    if (result !== 32'h0 || finish !== 1'b0 || finish_dash !== 1'b0 || res_ch !== 2'd0)
      $display("FAIL reset_out got=%h/%b/%b/%0d exp=0/0/0/0", result, finish, finish_dash, res_ch);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || inflight !== 3'd0) $display("FAIL reset_busy got=%b/%0d exp=0/0", busy, inflight);
    else n_pass++;
    n_chk++;
    if (core_x !== 34'h0 || core_y !== 34'h0 || held_out !== 128'h0)
      $display("FAIL reset_core got=%h/%h/%h exp=0", core_x, core_y, held_out);
    else n_pass++;
    idle(4);
  endtask

  task automatic test_basic();
    int t0;
    t0 = cyc;
    issue(1'b0, 2'd1, 32'h3F800000, 32'h40000000);
    start = 1'b0;
    while (cyc < t0 + 7) begin
      step();
      if (cyc == t0 + 4) begin
        n_chk++;
        if (finish !== 1'b1 || result !== 32'h40400000 || res_ch !== 2'd1)
          $display("FAIL basic got=%b/%h/%0d exp=1/40400000/1", finish, result, res_ch);
        else n_pass++;
      end
      if (cyc >= t0 + 5) begin
        n_chk++;
        if (held_out[63:32] !== 32'h40400000) $display("FAIL basic_held got=%h exp=40400000", held_out[63:32]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        to [3];
    logic [31:0] te [3];
    int t0;
    ta = '{32'h80000000, 32'h7F800000, 32'h7FC00000};
    tb = '{32'h80000000, 32'h3F800000, 32'h3F800000};
    to = '{1'b0, 1'b0, 1'b1};
    te = '{32'h00000000, 32'h7F800000, 32'h7FC00000};
    t0 = cyc;
    for (int i = 0; i < 3; i++) issue(to[i], 2'(i), ta[i], tb[i]);
    start = 1'b0;
    while (cyc < t0 + 8) begin
      step();
      if (cyc >= t0 + 4 && cyc <= t0 + 6) begin
        n_chk++;
        if (finish !== 1'b1 || result !== te[cyc-t0-4])
          $display("FAIL special%0d got=%b/%h exp=1/%h", cyc - t0 - 4, finish, result, te[cyc-t0-4]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int peak;
    logic [31:0] exp_r;
    t0 = cyc;
    peak = 0;
    for (int i = 0; i < 4; i++) issue(1'(i % 2), 2'(i), 32'h40A00000, 32'h40400000);
    start = 1'b0;
    while (cyc < t0 + 10) begin
      if (int'(inflight) > peak) peak = int'(inflight);
      step();
      if (cyc >= t0 + 4 && cyc <= t0 + 7) begin
        exp_r = ((cyc - t0 - 4) % 2 == 0) ? 32'h41000000 : 32'h40000000;
        n_chk++;
        if (finish !== 1'b1 || res_ch !== 2'(cyc - t0 - 4) || result !== exp_r)
          $display("FAIL b2b%0d got=%b/%0d/%h exp=1/%0d/%h", cyc - t0 - 4, finish, res_ch, result,
                   cyc - t0 - 4, exp_r);
        else n_pass++;
      end
    end
    n_chk++;
    if (peak != 4) $display("FAIL b2b_peak got=%0d exp=4", peak);
    else n_pass++;
  endtask

  task automatic test_clear();
    int t1;
    issue(1'b0, 2'd2, 32'h40A00000, 32'h00000000);
    idle(6);
    n_chk++;
    if (held_out[95:64] !== 32'h40A00000) $display("FAIL clear_pre got=%h exp=40a00000", held_out[95:64]);
    else n_pass++;
    t1 = cyc;
    issue(1'b0, 2'd0, 32'h3F800000, 32'h00000000);
    start = 1'b0;
    while (cyc < t1 + 5) step();
    n_chk++;
    if (finish_dash !== 1'b1) $display("FAIL clear_dash got=%b exp=1", finish_dash);
    else n_pass++;
    iter_reinit = 1'b0;
    step();
    iter_reinit = 1'b1;
    n_chk++;
    if (held_out !== {96'h0, 32'h3F800000}) $display("FAIL clear_post got=%h exp=%h", held_out, {96'h0, 32'h3F800000});
    else n_pass++;
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      iter_reinit = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 7) issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
      else idle(1);
    end
    iter_reinit = 1'b1;
    idle(8);
    n_chk++;
    if (q.size() != 0) $display("FAIL random_drain got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  task automatic test_midflight_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 2'(i), 32'h3F800000, 32'h3F800000);
    do_reset(1);
    n_chk++;
    if (inflight !== 3'd0 || busy !== 1'b0 || finish !== 1'b0 || held_out !== 128'h0)
      $display("FAIL midreset got=%0d/%b/%b/%h exp=0/0/0/0", inflight, busy, finish, held_out);
    else n_pass++;
    idle(8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_clear();
    test_random();
    test_midflight_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
